// File: rtl/flashram_op_engine.sv
// ----------------------------------------------------------------------------
// flashram_op_engine
//
// Backend responder for FlashRAM operation jobs raised by the N64-side command
// decoder. Erase jobs write 32'hFFFF_FFFF over one 16 KiB sector or over the
// whole 128 KiB save region. Page-write jobs copy the 32-word page write
// buffer into one 128-byte page. Each memory access is one 32-bit word
// transaction on a request/ack bus.
//
// Optional build macro: FLASHRAM_WRITE_AND_EN
//   When defined, a page write reads each target word first and stores
//   (buffer & memory), which models FlashRAM programming (bits only 1 -> 0).
//   When undefined, page writes overwrite the word and mem_rdata is unused.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   operation_pending    job request level from the command decoder
//   write_or_erase       1 = erase, 0 = page write (sampled at job start)
//   sector_or_all        1 = chip erase, 0 = sector erase (sampled at start)
//   sector               page index (sampled at job start)
//   address / rdata      write-buffer read port; rdata lags address by 1 cycle
//   operation_done       one-cycle completion pulse
//   mem_request/mem_write/mem_address/mem_wdata   memory request side
//   mem_ack/mem_rdata    memory response side (single-cycle ack)
// ----------------------------------------------------------------------------
module flashram_op_engine #(
    parameter int                    MEM_ADDR_W = 26,
    parameter logic [MEM_ADDR_W-1:0] SAVE_BASE  = 26'h3FE_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  operation_pending,
    input  logic                  write_or_erase,
    input  logic                  sector_or_all,
    input  logic [9:0]            sector,
    output logic [4:0]            address,
    input  logic [31:0]           rdata,
    output logic                  operation_done,
    output logic                  mem_request,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_WR_FETCH,
        ST_WR_LOAD,
`ifdef FLASHRAM_WRITE_AND_EN
        ST_WR_READ,
`endif
        ST_WR_STORE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [14:0]           n_q, n_d;
    logic                  erase_q, erase_d;
    logic                  all_q, all_d;
    logic [9:0]            sector_q, sector_d;
    logic [31:0]           data_q, data_d;
    logic [4:0]            address_q, address_d;
    logic                  done_q, done_d;
    logic                  req_q, req_d;
    logic                  write_q, write_d;
    logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]           wdata_q, wdata_d;

`ifndef FLASHRAM_WRITE_AND_EN
    // Read data is only consumed by the read-modify-write build.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Byte offset inside the 128 KiB region. Building it by concatenation
    // makes it wrap at 17 bits, so it can never carry into SAVE_BASE bits.
    function automatic logic [16:0] word_offset(input logic        erase,
                                                input logic        all,
                                                input logic [9:0]  sec,
                                                input logic [14:0] n);
        if (!erase)   return {sec, n[4:0], 2'b00};
        else if (all) return {n, 2'b00};
        else          return {sec[9:7], n[11:0], 2'b00};
    endfunction

    // SAVE_BASE is 128 KiB aligned, so OR-ing in the offset is an add.
    function automatic logic [MEM_ADDR_W-1:0] full_addr(input logic [16:0] off);
        return SAVE_BASE | {{(MEM_ADDR_W-17){1'b0}}, off};
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        erase_d  = erase_q;
        all_d    = all_q;
        sector_d = sector_q;
        data_d   = data_q;
        done_d   = 1'b0;
        req_d    = req_q;
        write_d  = write_q;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (operation_pending) begin
                    erase_d  = write_or_erase;
                    all_d    = sector_or_all;
                    sector_d = sector;
                    n_d      = '0;
                    if (write_or_erase) begin
                        // First erase word is requested straight away.
                        state_d = ST_ERASE;
                        req_d   = 1'b1;
                        write_d = 1'b1;
                        wdata_d = 32'hFFFF_FFFF;
                        maddr_d = full_addr(word_offset(1'b1, sector_or_all, sector, '0));
                    end else begin
                        state_d = ST_WR_FETCH;
                    end
                end
            end

            ST_ERASE: begin
                if (req_q) begin
                    // Ack is only honoured while a request is outstanding.
                    if (mem_ack) begin
                        req_d = 1'b0;
                        n_d   = n_q + 15'd1;
                        if (n_q == (all_q ? 15'h7FFF : 15'h0FFF)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    // The request stayed low for one cycle after the last ack.
                    req_d   = 1'b1;
                    maddr_d = full_addr(word_offset(1'b1, all_q, sector_q, n_q));
                end
            end

            // address_q already holds n; the buffer returns the word next cycle.
            ST_WR_FETCH: state_d = ST_WR_LOAD;

            ST_WR_LOAD: begin
                data_d  = rdata;
                req_d   = 1'b1;
                maddr_d = full_addr(word_offset(1'b0, 1'b0, sector_q, n_q));
`ifdef FLASHRAM_WRITE_AND_EN
                write_d = 1'b0;
                state_d = ST_WR_READ;
`else
                write_d = 1'b1;
                wdata_d = rdata;
                state_d = ST_WR_STORE;
`endif
            end

`ifdef FLASHRAM_WRITE_AND_EN
            ST_WR_READ: begin
                if (req_q && mem_ack) begin
                    data_d  = data_q & mem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_WR_STORE;
                end
            end
`endif

            ST_WR_STORE: begin
                if (req_q) begin
                    if (mem_ack) begin
                        req_d = 1'b0;
                        n_d   = n_q + 15'd1;
                        if (n_q[4:0] == 5'd31) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WR_FETCH;
                        end
                    end
                end else begin
                    // Reached after the read phase: issue the merged write.
                    req_d   = 1'b1;
                    write_d = 1'b1;
                    wdata_d = data_q;
                end
            end

            // Hold here until the decoder drops pending so a job cannot re-fire.
            ST_DONE: if (!operation_pending) state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // Buffer index follows the next word count so it is valid in WR_FETCH.
        address_d = n_d[4:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // asynchronous reset clears every flop, including all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            erase_q   <= 1'b0;
            all_q     <= 1'b0;
            sector_q  <= '0;
            data_q    <= '0;
            address_q <= '0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            erase_q   <= erase_d;
            all_q     <= all_d;
            sector_q  <= sector_d;
            data_q    <= data_d;
            address_q <= address_d;
            done_q    <= done_d;
            req_q     <= req_d;
            write_q   <= write_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign address        = address_q;
    assign operation_done = done_q;
    assign mem_request    = req_q;
    assign mem_write      = write_q;
    assign mem_address    = maddr_q;
    assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_flashram_op_engine.sv
// ----------------------------------------------------------------------------
// tb_flashram_op_engine
//
// Drives erase and page-write jobs into flashram_op_engine, answers the memory
// bus with random ack latency, and compares every bus transaction and the
// resulting memory image against a reference model of the save region.
// ----------------------------------------------------------------------------
module tb_flashram_op_engine;

    localparam logic [25:0] BASE = 26'h3FE_0000;
`ifdef FLASHRAM_WRITE_AND_EN
    localparam bit AND_MODE = 1'b1;
`else
    localparam bit AND_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        operation_pending;
    logic        write_or_erase;
    logic        sector_or_all;
    logic [9:0]  sector;
    logic [4:0]  address;
    logic [31:0] rdata;
    logic        operation_done;
    logic        mem_request;
    logic        mem_write;
    logic [25:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    flashram_op_engine dut (
        .clk               (clk),
        .reset             (reset),
        .operation_pending (operation_pending),
        .write_or_erase    (write_or_erase),
        .sector_or_all     (sector_or_all),
        .sector            (sector),
        .address           (address),
        .rdata             (rdata),
        .operation_done    (operation_done),
        .mem_request       (mem_request),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [25:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] bus_mem [32768];
    logic [31:0] ref_mem [32768];
    logic [31:0] wbuf    [32];

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_txn        = 0;
    int n_wr         = 0;
    int txn_err      = 0;
    int stable_err   = 0;
    int done_cnt     = 0;
    int max_delay    = 0;
    bit spurious_en  = 0;

    // Synchronous-read page buffer.
    always @(posedge clk) rdata <= wbuf[address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: random ack latency, optional stray acks while idle.
    initial begin : responder
        bit          in_txn = 0;
        int          wait_left = 0;
        logic [25:0] h_addr;
        logic [31:0] h_wdata;
        logic        h_write;
        txn_t        e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_request) begin
                if (!in_txn) begin
                    in_txn    = 1;
                    wait_left = $urandom_range(0, max_delay);
                    h_addr    = mem_address;
                    h_wdata   = mem_wdata;
                    h_write   = mem_write;
                end else if (mem_address !== h_addr || mem_write !== h_write ||
                             (h_write && mem_wdata !== h_wdata)) begin
                    stable_err++;
                end
                if (wait_left == 0) begin
                    in_txn = 0;
                    n_txn++;
                    if (mem_address[25:17] !== BASE[25:17] || mem_address[1:0] !== 2'b00)
                        txn_err++;
                    if (exp_q.size() == 0) begin
                        txn_err++;
                    end else begin
                        e = exp_q.pop_front();
                        if (e.wr != mem_write || e.addr !== mem_address ||
                            (e.wr && e.data !== mem_wdata))
                            txn_err++;
                    end
                    if (mem_write) begin
                        bus_mem[mem_address[16:2]] = mem_wdata;
                        n_wr++;
                    end else begin
                        mem_rdata = bus_mem[mem_address[16:2]];
                    end
                    mem_ack = 1'b1;
                end else begin
                    wait_left--;
                end
            end else begin
                in_txn = 0;
                if (spurious_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (operation_done === 1'b1) done_cnt++;
        end
    end

    // Reference model: expected bus transactions and the new memory image.
    // Only the first 'nwords' words are applied to the reference memory.
    task automatic build_job(input bit erase, input bit all, input logic [9:0] sec, input int nwords);
        int   cnt;
        int   base_off;
        int   off;
        txn_t t;
        if (erase) begin
            cnt      = all ? 32768 : 4096;
            base_off = all ? 0 : int'(sec[9:7]) * 16384;
            for (int i = 0; i < cnt; i++) begin
                off    = (base_off + 4 * i) % 131072;
                t.wr   = 1;
                t.addr = BASE + 26'(off);
                t.data = 32'hFFFF_FFFF;
                exp_q.push_back(t);
                ref_mem[off / 4] = 32'hFFFF_FFFF;
            end
        end else begin
            base_off = int'(sec) * 128;
            for (int i = 0; i < 32; i++) begin
                off    = (base_off + 4 * i) % 131072;
                t.addr = BASE + 26'(off);
                if (AND_MODE) begin
                    t.wr   = 0;
                    t.data = '0;
                    exp_q.push_back(t);
                end
                t.wr   = 1;
                t.data = AND_MODE ? (ref_mem[off / 4] & wbuf[i]) : wbuf[i];
                exp_q.push_back(t);
                if (i < nwords) ref_mem[off / 4] = t.data;
            end
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 32768; i++)
            if (bus_mem[i] !== ref_mem[i]) bad++;
        check({tag, "_mem_image"}, bad, 0);
    endtask

    task automatic run_job(input string tag, input bit erase, input bit all, input logic [9:0] sec,
                           input int dly, input bit spur, input bit drop);
        int base_txn  = n_txn;
        int base_done = done_cnt;
        int exp_n;
        bit seen = 0;
        exp_n       = erase ? (all ? 32768 : 4096) : (AND_MODE ? 64 : 32);
        max_delay   = dly;
        spurious_en = spur;
        txn_err     = 0;
        stable_err  = 0;
        build_job(erase, all, sec, 32);
        @(negedge clk);
        write_or_erase    = erase;
        sector_or_all     = all;
        sector            = sec;
        operation_pending = 1'b1;
        for (int cyc = 0; cyc < 80000 && !seen; cyc++) begin
            @(negedge clk);
            if (operation_done === 1'b1) begin
                seen = 1;
            end else if (cyc >= 2) begin
                // Inputs are sampled only at job start; scramble them mid-job.
                write_or_erase = 1'($urandom);
                sector_or_all  = 1'($urandom);
                sector         = 10'($urandom);
                if (drop) operation_pending = 1'b0;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        // With pending still high the engine must stay quiet.
        if (operation_pending) repeat (20) @(negedge clk);
        operation_pending = 1'b0;
        spurious_en       = 0;
        repeat (3) @(negedge clk);
        check({tag, "_txn_count"}, n_txn - base_txn, exp_n);
        check({tag, "_done_pulses"}, done_cnt - base_done, 1);
        check({tag, "_txn_errors"}, txn_err, 0);
        check({tag, "_stable_errors"}, stable_err, 0);
        check({tag, "_leftover"}, exp_q.size(), 0);
        compare_mem(tag);
    endtask

    initial begin : main
        logic [31:0] old_w;
        int          base_wr;
        int          base_done;
        int          base_txn;
        bit          hit;

        reset             = 1'b1;
        operation_pending = 1'b0;
        write_or_erase    = 1'b0;
        sector_or_all     = 1'b0;
        sector            = '0;
        for (int i = 0; i < 32768; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        #1;
        check("reset_ctrl", {address, operation_done, mem_request, mem_write}, 0);
        check("reset_bus", {mem_address, mem_wdata}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", {address, operation_done, mem_request, mem_write}, 0);

        // Directed page write, ack one cycle after request.
        for (int i = 0; i < 32; i++) wbuf[i] = 32'hA5A5_0000 + 32'(i);
        old_w = ref_mem[160];
        run_job("page5", 1'b0, 1'b0, 10'h005, 0, 1'b0, 1'b0);
        check("page5_word0", bus_mem[160], AND_MODE ? (old_w & 32'hA5A5_0000) : 32'hA5A5_0000);

        // Programming case: memory 0xF0F0FFFF, buffer 0xFF00FF00.
        bus_mem[96] = 32'hF0F0_FFFF;
        ref_mem[96] = 32'hF0F0_FFFF;
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        wbuf[0] = 32'hFF00_FF00;
        run_job("prog", 1'b0, 1'b0, 10'h003, 2, 1'b0, 1'b0);
        check("prog_word0", bus_mem[96], AND_MODE ? 32'hF000_FF00 : 32'hFF00_FF00);

        // Random page writes with stalls, stray acks and pending dropped mid-job.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
            run_job($sformatf("rand%0d", j), 1'b0, 1'b0, 10'($urandom), 7, 1'b1, 1'($urandom));
        end

        // Sector erase of sector 0x0FF -> offsets 0x4000..0x7FFC.
        run_job("sector_erase", 1'b1, 1'b0, 10'h0FF, 0, 1'b0, 1'b0);

        // Reset after 12 words of a page write.
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        max_delay  = 3;
        base_wr    = n_wr;
        base_done  = done_cnt;
        hit        = 0;
        build_job(1'b0, 1'b0, 10'h2A7, 12);
        @(negedge clk);
        write_or_erase    = 1'b0;
        sector_or_all     = 1'b0;
        sector            = 10'h2A7;
        operation_pending = 1'b1;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(negedge clk);
            #1;
            if (n_wr - base_wr == 12) hit = 1;
        end
        check("rst_reached_word12", hit, 1);
        #1 reset = 1'b1;
        #1;
        check("rst_async_ctrl", {address, operation_done, mem_request, mem_write}, 0);
        check("rst_async_bus", {mem_address, mem_wdata}, 0);
        operation_pending = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        base_txn = n_txn;
        repeat (10) @(negedge clk);
        check("rst_no_done", done_cnt - base_done, 0);
        check("rst_no_requests", n_txn - base_txn, 0);
        compare_mem("rst");

        // A fresh job after reset starts from word 0.
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        run_job("after_rst", 1'b0, 1'b0, 10'h2A7, 4, 1'b0, 1'b0);

        // Chip erase covering the whole region; sector is ignored.
        run_job("chip_erase", 1'b1, 1'b1, 10'h3FF, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/flashram_op_engine.md
Name: flashram_op_engine

Overview:
- Backend responder on the FlashRAM operation interface: services erase and page-write jobs raised by the N64-side FlashRAM command decoder.
- Reads the 32-word page write buffer through its synchronous read port.
- Performs the jobs as 32-bit word transactions on a request/ack memory bus into the 128 KiB save region.
- Reports completion with a one-cycle done pulse.

Parameters:
- MEM_ADDR_W, 26, width of the memory byte address.
- SAVE_BASE, 26'h3FE_0000, byte base of the 128 KiB FlashRAM region; must be 128 KiB aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- operation_pending  in  1  job request level from the command decoder
- write_or_erase  in  1  1 = erase, 0 = page write; sampled at job start
- sector_or_all  in  1  erase scope: 1 = whole chip, 0 = one sector; sampled at job start
- sector  in  10  page index; sampled at job start
- address  out  5  write-buffer word index
- rdata  in  32  write-buffer data, valid 1 cycle after address
- operation_done  out  1  single-cycle completion pulse
- mem_request  out  1  memory transaction request
- mem_write  out  1  1 = write, 0 = read
- mem_address  out  MEM_ADDR_W  word-aligned byte address; bits [1:0] are always 0
- mem_wdata  out  32  write data
- mem_ack  in  1  transaction complete, single-cycle
- mem_rdata  in  32  read data, valid with mem_ack (used only with the optional feature)

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, word counter 0.
- States: IDLE, ERASE, WR_FETCH, WR_LOAD, WR_READ (optional feature only), WR_STORE, DONE.
- IDLE:
  - When operation_pending=1, latch write_or_erase, sector_or_all and sector.
  - Clear counter n (15 bit).
  - Go to ERASE if erase, else WR_FETCH.
- Erase range:
  - Sector erase: 4096 words at SAVE_BASE + {sector[9:7], 14'b0} + 4n; sector[6:0] ignored.
  - Chip erase: 32768 words at SAVE_BASE + 4n; sector ignored.
- ERASE:
  - Assert mem_request with mem_write=1 and mem_wdata=32'hFFFF_FFFF.
  - Hold address/data stable until mem_ack.
  - On ack, increment n; after the last word go to DONE.
  - Request drops for at least 1 cycle between words.
- Write range: 32 words at SAVE_BASE + {sector, 7'b0} + 4n, n = 0..31.
- WR_FETCH: drive address=n[4:0]; go to WR_LOAD next cycle.
- WR_LOAD: latch rdata into the data register; go to WR_STORE (or WR_READ with the feature).
- WR_STORE:
  - Write the data register; on mem_ack increment n.
  - If n was 31 go to DONE, else go to WR_FETCH.
- DONE:
  - Pulse operation_done for exactly 1 cycle, on entry.
  - Remain in DONE until operation_pending=0, then go to IDLE.
  - This stops a job from re-triggering while the decoder is still clearing its pending flag.
- Address arithmetic wraps inside the 17-bit region offset; it never carries into SAVE_BASE bits.
- Job parameters are sampled once at start. Input changes during a job are ignored, including operation_pending dropping mid-job; the job completes and pulses done.
- mem_ack outside a requesting cycle is ignored.
- Reset mid-job: the job is abandoned immediately, with no done pulse and no further memory requests.
- Throughput: erase is 1 word per ack plus 1 idle cycle. Write adds 2 buffer-fetch cycles per word.

Optional Feature:
- Macro: FLASHRAM_WRITE_AND_EN.
- Defined:
  - A page write models real FlashRAM programming: a bit can only go from 1 to 0.
  - WR_LOAD goes to WR_READ.
  - WR_READ issues a read (mem_write=0) at the same address.
  - On mem_ack the data register becomes data & mem_rdata; then WR_STORE.
- Undefined:
  - WR_READ is absent, mem_rdata is unused, and the write overwrites the word directly.
- Erase behaviour is identical in both builds.

Test Plan:
- Write page: sector=10'h005, buffer word i = 32'hA5A5_0000+i, mem_ack 1 cycle after request → exactly 32 writes at SAVE_BASE+0x280+4i with matching data; one done pulse; no activity afterwards while pending is held high.
- Sector erase: sector=10'h0FF → 4096 writes of FFFF_FFFF starting at SAVE_BASE+0x4000, ending at SAVE_BASE+0x7FFC; done pulses once.
- Chip erase: sector_or_all=1, sector=10'h3FF → 32768 writes covering SAVE_BASE..SAVE_BASE+0x1FFFC; the address never exceeds the region.
- Handshake stall: mem_ack delayed 0–7 random cycles → mem_address and mem_wdata are stable while mem_request=1; the word count is still exact.
- Reset at write word 12 → all outputs 0 asynchronously; no done pulse; a new job after reset starts again at word 0.
- Feature build, FLASHRAM_WRITE_AND_EN: memory word 0xF0F0_FFFF, buffer word 0xFF00_FF00 → read then write of 0xF000_FF00.
